// File: rtl/pattern_serializer_if.sv
// pattern_serializer_if
//   Groups the word-side handshake and serial output of the pattern
//   serializer so the upstream source and the serializer share one bundle.
//   Signals:
//     din        parallel word, WIDTH bits
//     load       word-valid strobe from upstream
//     ready      serializer can take a word on the next falling clock edge
//     out        serial bit stream, LSB first
//     out_valid  out carries a data bit (otherwise the idle level)
//     word_done  last bit of a word is on out this cycle
//   Modports:
//     master  upstream word source (drives din/load, observes the rest)
//     slave   the serializer itself
interface pattern_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic             word_done;

  modport master (
    output din,
    output load,
    input  ready,
    input  out,
    input  out_valid,
    input  word_done
  );

  modport slave (
    input  din,
    input  load,
    output ready,
    output out,
    output out_valid,
    output word_done
  );
endinterface

// File: rtl/pattern_serializer.sv
// pattern_serializer
//   Converts WIDTH-bit parallel words into an LSB-first serial stream for a
//   downstream pattern detector. A one-word holding register lets the next
//   word be accepted while the current one shifts, so back-to-back words
//   come out with no idle bubble. All state moves on the falling edge of
//   clk to line up with the detector.
//   Ports:
//     clk    clock, state updates on its falling edge
//     reset  asynchronous, active-low reset
//     bus    pattern_serializer_if slave modport (din, load, ready,
//            out, out_valid, word_done)
//   Parameters:
//     WIDTH     bits per parallel word (2..16)
//     IDLE_BIT  level driven on out while nothing is shifting
module pattern_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  pattern_serializer_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;
  logic             accept;

  // ready is gated by reset directly so it drops the instant reset asserts,
  // not just once the registers have cleared.
  assign bus.ready = reset && !hold_full;
  assign accept    = bus.load && bus.ready;

  // Outputs decode only registered state, so out never glitches with din/load.
  assign bus.out       = (state == SHIFT) ? sh[0] : IDLE_BIT;
  assign bus.out_valid = (state == SHIFT);
  assign bus.word_done = (state == SHIFT) && (cnt == LAST);

  // Single FSM block: IDLE waits for a word, SHIFT walks sh one bit per
  // cycle. On the last bit the next word comes from hold if one is waiting,
  // otherwise straight from din if offered that very edge, otherwise idle.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh    <= bus.din;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            sh  <= sh >> 1;
            cnt <= cnt + 1'b1;
            if (accept) begin
              hold      <= bus.din;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            sh        <= hold;
            hold_full <= 1'b0;
            cnt       <= '0;
          end else if (accept) begin
            sh  <= bus.din;
            cnt <= '0;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer
//   Directed bench for pattern_serializer (WIDTH=8, IDLE_BIT=1). Accepted
//   words push their expected bit sequence into a scoreboard queue; a
//   monitor on the rising edge (opposite the active falling edge) pops one
//   entry per valid output bit, and flags any gap while bits are pending.
module tb_pattern_serializer;

  localparam int WIDTH = 8;

  typedef struct {
    logic b;
    logic wd;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  pattern_serializer_if #(.WIDTH(WIDTH)) bus ();

  pattern_serializer #(
    .WIDTH    (WIDTH),
    .IDLE_BIT (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Call right after a rising edge. Holds load until the serializer takes
  // the word, then queues its LSB-first bits.
  task automatic send(input logic [WIDTH-1:0] d);
    bit done = 0;
    bus.din  = d;
    bus.load = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.ready) begin
        @(negedge clk);
        #1;
        for (int k = 0; k < WIDTH; k++) sb.push_back('{b: d[k], wd: (k == WIDTH - 1)});
        done = 1;
      end else begin
        @(negedge clk);
        @(posedge clk);
      end
    end
    bus.load = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: word %0h not accepted, expected acceptance", d);
    end
  endtask

  task automatic drain(input string name);
    repeat (WIDTH + 4) @(posedge clk);
    check(name, sb.size(), 0);
  endtask

  // Monitor: compare each valid bit against the scoreboard; idle cycles must
  // show the idle level and must not occur while bits are still expected.
  always @(posedge clk) begin
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL extra_bit: got out=%0b with nothing expected", bus.out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_bit", bus.out, e.b);
        check("word_done", bus.word_done, e.wd);
      end
    end else begin
      check("idle_out", bus.out, 1'b1);
      check("idle_word_done", bus.word_done, 1'b0);
      if (sb.size() != 0) check("gap_pending", sb.size(), 0);
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    bus.din  = '0;
    bus.load = 1'b0;
    reset    = 1'b0;
    #1;
    check("rst_out", bus.out, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_ready", bus.ready, 1'b0);
    check("rst_word_done", bus.word_done, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    check("ready_after_rst", bus.ready, 1'b1);

    // Single word
    send(8'hF2);
    drain("single_drain");

    // Back-to-back: second word offered while bit index 1 is on out
    @(posedge clk);
    send(8'hF2);
    @(posedge clk);
    @(posedge clk);
    send(8'h08);
    @(posedge clk);
    check("b2b_ready_low", bus.ready, 1'b0);
    repeat (5) @(posedge clk);
    check("b2b_ready_bit8", bus.ready, 1'b0);
    @(posedge clk);
    check("b2b_ready_back", bus.ready, 1'b1);
    drain("b2b_drain");

    // Direct load on the last-bit edge with hold empty
    @(posedge clk);
    send(8'hF2);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk);
        if (bus.word_done) seen = 1;
      end
      check("wd_seen", seen, 1'b1);
    end
    send(8'hAA);
    @(posedge clk);
    check("direct_ready", bus.ready, 1'b1);
    drain("direct_drain");

    // Blocked load while hold is full, plus din wiggling with load low
    @(posedge clk);
    send(8'hF2);
    @(posedge clk);
    send(8'h3C);
    @(posedge clk);
    check("blocked_ready", bus.ready, 1'b0);
    bus.din  = 8'h55;
    bus.load = 1'b1;
    @(posedge clk);
    bus.load = 1'b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      bus.din = 8'(i * 37 + 5);
      @(posedge clk);
    end
    check("blocked_drain", sb.size(), 0);

    // Reset mid-word during bit index 3
    @(posedge clk);
    send(8'hF2);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    check("midrst_out", bus.out, 1'b1);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_ready", bus.ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    check("midrst_ready_back", bus.ready, 1'b1);
    drain("midrst_no_residual");

    // Fresh word after reset release
    @(posedge clk);
    send(8'h5A);
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of bits per parallel word; legal range 2..16.
REQ-002 Parameter IDLE_BIT, default 1'b1, is the value driven on out when no word is shifting.
REQ-003 clk  input  1  single clock; all state updates on the falling edge, matching the downstream pattern detector.
REQ-004 reset  input  1  asynchronous, active-low reset: 0 resets immediately, independent of clk.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 load  input  1  word-valid strobe; a word is accepted on a falling edge where load=1 and ready=1.
REQ-007 ready  output  1  1 when the holding register is empty and a word can be accepted.
REQ-008 out  output  1  serial bit stream, LSB first; connects to the detector's serial input.
REQ-009 out_valid  output  1  1 while out carries a data bit, 0 while out carries IDLE_BIT.
REQ-010 word_done  output  1  1 for exactly the cycle in which the last bit (din[WIDTH-1]) of a word is on out.

Function
REQ-011 Storage SHALL be a WIDTH-bit shift register sh, a WIDTH-bit holding register hold with flag hold_full, and a bit counter cnt of ceil(log2(WIDTH)) bits.
REQ-012 The FSM SHALL have two states: IDLE (nothing shifting) and SHIFT (sh active).
REQ-013 ready SHALL equal !hold_full while reset=1, and SHALL be 0 while reset=0.
REQ-014 In SHIFT: out=sh[0] and out_valid=1. In IDLE: out=IDLE_BIT and out_valid=0. Both are decoded from registered state only.
REQ-015 word_done SHALL be (state==SHIFT && cnt==WIDTH-1).
REQ-016 IDLE with an accepted load: sh<=din, cnt<=0, state<=SHIFT, hold is bypassed. din[0] appears on out in the cycle after the accepting edge, giving a latency of 1 cycle.
REQ-017 SHIFT with cnt<WIDTH-1: sh<=sh>>1, cnt<=cnt+1. An accepted load in this cycle writes hold<=din and hold_full<=1.
REQ-018 SHIFT with cnt==WIDTH-1 and hold_full=1: sh<=hold, hold_full<=0, cnt<=0, stay in SHIFT. There is no idle bubble between words.
REQ-019 SHIFT with cnt==WIDTH-1, hold_full=0 and an accepted load: sh<=din, cnt<=0, stay in SHIFT, hold remains empty.
REQ-020 SHIFT with cnt==WIDTH-1, hold_full=0 and no load: state<=IDLE, cnt<=0.
REQ-021 load while ready=0 SHALL be ignored: no state change, and the word is lost (the upstream side must hold load until ready).
REQ-022 Sustained throughput SHALL be one word per WIDTH cycles, with out_valid continuously 1 while words are supplied back-to-back.
REQ-023 A changing din while load=0 SHALL have no effect.

Reset
REQ-024 reset=0 SHALL asynchronously force: state=IDLE, sh=0, hold=0, hold_full=0, cnt=0, so out=IDLE_BIT, out_valid=0, word_done=0, ready=0.
REQ-025 reset asserted mid-word SHALL discard both the shifting word and the held word. No partial bit stream resumes after release.
REQ-026 After reset deassertion, ready=1, and the first falling edge with load=1 is accepted per REQ-016.

Verification
REQ-027 Single word: WIDTH=8, load din=8'hF2 in IDLE -> out over the next 8 cycles = 0,1,0,0,1,1,1,1; out_valid=1 for those 8 cycles only; word_done on the 8th; then out=1, out_valid=0.
REQ-028 Back-to-back: load 8'hF2, then load 8'h08 during bit 2 of the first word -> ready=0 from the next cycle until bit 8; 16 contiguous valid bits 0,1,0,0,1,1,1,1,0,0,0,1,0,0,0,0; no gap.
REQ-029 Last-bit direct load: hold empty, load 8'hAA exactly on the word_done edge -> the next cycle out=0 (bit0 of AA) with out_valid=1; ready stays 1.
REQ-030 Blocked load: hold_full=1, pulse load with din=8'h55 -> word ignored, out stream unchanged, hold contents unchanged.
REQ-031 Reset mid-word: assert reset low between edges during bit 4 -> out=1, out_valid=0, ready=0 immediately; after release, ready=1 and no residual bits appear.
REQ-032 End-to-end: drive out/clk/reset into the downstream pattern detector with the word stream from REQ-028 -> the detector's z pulses at the positions predicted by its 0100/00010 pattern model.
